ternary_mvm_serial: RTL
=======================

TERNARY_MVM_SERIAL -- requirements
Module: ternary_mvm_serial

Interface
REQ-001 SHALL have parameter IN_LEN, default 12, meaning input vector length (columns).
REQ-002 SHALL have parameter OUT_LEN, default 6, meaning output vector length (rows).
REQ-003 SHALL have parameter BIT_WIDTH, default 8, meaning activation width, streamed one bit-plane per beat, LSB first.
REQ-004 SHALL have parameter OUT_WIDTH, default 8, meaning saturation width when sat_en=1.
REQ-005 SHALL have local parameter ACC_WIDTH = BIT_WIDTH + clog2(IN_LEN) + 1, signed.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port start, input, 1, which begins a job when the block is IDLE.
REQ-009 SHALL have port signed_mode, input, 1, which treats activations as two's complement; sampled with start.
REQ-010 SHALL have port sat_en, input, 1, which enables output saturation; sampled with start.
REQ-011 SHALL have port weights, input, 2*IN_LEN*OUT_LEN, giving row r at bits [r*2*IN_LEN +: 2*IN_LEN]: low IN_LEN bits are the +1 mask, high IN_LEN bits are the -1 mask; sampled with start.
REQ-012 SHALL have port in_valid, input, 1, meaning the bit-plane on in_bits is valid.
REQ-013 SHALL have port in_ready, output, 1, meaning the block accepts a bit-plane.
REQ-014 SHALL have port in_bits, input, IN_LEN, carrying bit k of every activation on beat k.
REQ-015 SHALL have port out_valid, output, 1, meaning the result vector is valid.
REQ-016 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-017 SHALL have port out_data, output, OUT_LEN*ACC_WIDTH, carrying signed row results, row r at [r*ACC_WIDTH +: ACC_WIDTH].

Function
REQ-018 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-019 SHALL, in IDLE with start=1, snapshot weights, signed_mode and sat_en, clear accumulators and the beat counter, and enter RUN next cycle; start SHALL be ignored in RUN and DONE.
REQ-020 SHALL assert in_ready only in RUN; a beat SHALL be accepted only on in_valid&in_ready; cycles with in_valid=0 SHALL NOT advance the beat counter.
REQ-021 SHALL decode per element a weight of -1 if the neg bit is set (neg has priority when both bits are set), +1 if only the pos bit is set, else 0.
REQ-022 SHALL, per accepted beat k, compute per row s = popcount(pos & in_bits & ~neg) - popcount(neg & in_bits), in range [-IN_LEN, IN_LEN].
REQ-023 SHALL add s<<k to the row accumulator; when signed_mode=1 and k=BIT_WIDTH-1, SHALL subtract s<<k instead.
REQ-024 SHALL, after beat BIT_WIDTH-1 is accepted, enter DONE next cycle with out_valid=1.
REQ-025 SHALL, when sat_en=1, clamp each row to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], sign-extended to ACC_WIDTH; otherwise SHALL output the full accumulator unmodified.
REQ-026 SHALL hold out_data and out_valid stable in DONE until out_ready=1, then return to IDLE next cycle; out_ready outside DONE SHALL be ignored.
REQ-027 SHALL keep accumulators wide enough that no overflow occurs for any input (ACC_WIDTH rule).

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-RUN, immediately force IDLE, in_ready=0, out_valid=0, out_data=0, and clear accumulators, beat counter and snapshot registers.
REQ-029 SHALL require a fresh start after reset; no partial job SHALL resume.

Structure
REQ-030 SHALL place the FSM state enum, weight-encoding bit positions, and the ACC_WIDTH calculation in shared package tmult_pkg.
REQ-031 SHALL instantiate OUT_LEN copies of sub-module ternary_row_acc (ternary decode, popcount difference, shift-add accumulate, saturation).

Verification
REQ-032 SHALL check: row0 all +1, signed_mode=0, sat_en=0, activations all 255 -> row0 = 3060, other rows (weights 0) = 0.
REQ-033 SHALL check: row0 all -1, signed_mode=1, activations all -128 -> row0 = +1536; row1 all +1 -> -1536.
REQ-034 SHALL check: sat_en=1, OUT_WIDTH=8, the case of REQ-032 -> row0 = 127; a -1536 result -> -128.
REQ-035 SHALL check: in_valid toggled 1,0,0,1,... -> exactly BIT_WIDTH accepted beats, correct result, out_valid one cycle after the last accepted beat.
REQ-036 SHALL check: out_ready held 0 for 5 cycles in DONE with start=1 -> out_data stable, no new job starts; the cycle after out_ready=1 the block is IDLE.
REQ-037 SHALL check: rst_n pulsed low after 3 beats -> all outputs 0 asynchronously; a new job then yields a correct, uncorrupted result.

Source files
------------

// File: rtl/tmult_pkg.sv
// Shared types and sizing for the ternary matrix-vector unit.
// Holds the FSM encoding, weight field positions and accumulator sizing.
package tmult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Field index inside one row's 2*IN_LEN weight slice.
    localparam int W_POS = 0;
    localparam int W_NEG = 1;

    // Sign bit plus enough headroom for IN_LEN full-scale activations.
    function automatic int acc_width(input int bit_width, input int in_len);
        return bit_width + $clog2(in_len) + 1;
    endfunction

endpackage

// File: rtl/ternary_row_acc.sv
// One output row: ternary decode, popcount difference, shift-add accumulate.
// Saturation is applied on the read side so the accumulator stays exact.
module ternary_row_acc
    import tmult_pkg::*;
#(
    parameter int IN_LEN    = 12,
    parameter int OUT_WIDTH = 8,
    parameter int ACC_WIDTH = 13,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 neg_beat,
    input  logic [CNT_W-1:0]     beat,
    input  logic [IN_LEN-1:0]    pos,
    input  logic [IN_LEN-1:0]    neg,
    input  logic [IN_LEN-1:0]    bits,
    input  logic                 sat_en,
    output logic [ACC_WIDTH-1:0] result
);

    localparam int SAT_W = (OUT_WIDTH < ACC_WIDTH) ? OUT_WIDTH : ACC_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] term;
    logic [IN_LEN-1:0]           hit_pos;
    logic [IN_LEN-1:0]           hit_neg;
    int                          pc_pos;
    int                          pc_neg;

    // Neg wins over pos; count +1 and -1 hits on this bit-plane.
    always_comb begin
        hit_pos = pos & ~neg & bits;
        hit_neg = neg & bits;
        pc_pos  = 0;
        pc_neg  = 0;
        for (int i = 0; i < IN_LEN; i++) begin
            pc_pos = pc_pos + int'(hit_pos[i]);
            pc_neg = pc_neg + int'(hit_neg[i]);
        end
        term = ACC_WIDTH'(pc_pos - pc_neg) <<< beat;
    end

    // Accumulate the weighted plane; the sign plane subtracts in signed mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= neg_beat ? acc_q - term : acc_q + term;
        end
    end

    // Optional clamp to the narrower output range, sign-extended.
    always_comb begin
        result = acc_q;
        if (sat_en) begin
            if (acc_q > SAT_MAX) begin
                result = SAT_MAX;
            end else if (acc_q < SAT_MIN) begin
                result = SAT_MIN;
            end
        end
    end

endmodule

// File: rtl/ternary_mvm_serial.sv
// Bit-serial ternary matrix-vector multiply, one activation bit-plane per beat.
// Weights and mode bits are captured at start and held for the whole job.
module ternary_mvm_serial
    import tmult_pkg::*;
#(
    parameter int IN_LEN    = 12,
    parameter int OUT_LEN   = 6,
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 8,
    localparam int ACC_WIDTH = acc_width(BIT_WIDTH, IN_LEN)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           signed_mode,
    input  logic                           sat_en,
    input  logic [2*IN_LEN*OUT_LEN-1:0]    weights,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_LEN-1:0]              in_bits,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_LEN*ACC_WIDTH-1:0]   out_data
);

    localparam int CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BIT_WIDTH - 1);

    state_t                        state_q;
    state_t                        state_d;
    logic [CNT_W-1:0]              cnt_q;
    logic [2*IN_LEN*OUT_LEN-1:0]   w_q;
    logic                          sm_q;
    logic                          sat_q;
    logic                          clr;
    logic                          accept;
    logic                          last;

    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign clr       = (state_q == ST_IDLE) && start;
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == LAST_BEAT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start only counts in IDLE, out_ready only in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (accept && last) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Job snapshot and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '0;
            sm_q  <= 1'b0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else if (clr) begin
            w_q   <= weights;
            sm_q  <= signed_mode;
            sat_q <= sat_en;
            cnt_q <= '0;
        end else if (accept && !last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    for (genvar r = 0; r < OUT_LEN; r++) begin : g_row
        logic [ACC_WIDTH-1:0] res;

        ternary_row_acc #(
            .IN_LEN    (IN_LEN),
            .OUT_WIDTH (OUT_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .CNT_W     (CNT_W)
        ) u_row (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .en       (accept),
            .neg_beat (sm_q && last),
            .beat     (cnt_q),
            .pos      (w_q[r*2*IN_LEN + W_POS*IN_LEN +: IN_LEN]),
            .neg      (w_q[r*2*IN_LEN + W_NEG*IN_LEN +: IN_LEN]),
            .bits     (in_bits),
            .sat_en   (sat_q),
            .result   (res)
        );

        assign out_data[r*ACC_WIDTH +: ACC_WIDTH] =
            (state_q == ST_DONE) ? res : '0;
    end

endmodule
